// File: rtl/text_console_if.sv
// Character-in / text-RAM-write-out signal bundle for text_console_writer.
// master: the character source and RAM-side observer; slave: the writer block.
`timescale 1ns/1ps
interface text_console_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  write_address;
    logic [31:0] write_data;
    logic        write_en;

    modport master (
        output in_data, in_valid,
        input  in_ready, write_address, write_data, write_en
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, write_address, write_data, write_en
    );
endinterface

// File: rtl/text_console_writer.sv
// text_console_writer: turns a byte stream into packed 4-char word writes for
// the 80x25 text RAM, tracking a cursor and clearing rows as they are entered.
// Optional build macro TEXT_CONSOLE_CLEAR_ON_RESET_EN: when defined, reset
// enters a full-screen clear instead of going straight to IDLE.
`timescale 1ns/1ps
module text_console_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 25,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    text_console_if.slave     bus,
    output logic [4:0]        cursor_row,
    output logic [6:0]        cursor_col,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_SCREEN} state_t;

    localparam logic [8:0]  ROW_WORDS    = 9'(COLS / 4);
    localparam logic [8:0]  SCREEN_WORDS = 9'((COLS / 4) * ROWS);
    localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);
    localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
    localparam logic [31:0] BLANK_WORD   = {4{BLANK}};

`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLEAR_SCREEN;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t      state, state_d;
    logic [8:0]  clr_cnt, clr_cnt_d;       // index of the next clear write to issue
    logic [4:0]  target_row, target_row_d; // row being cleared / entered
    logic [31:0] cur_word, cur_word_d;     // last word written on the cursor's row
    logic [4:0]  row_d;
    logic [6:0]  col_d;
    logic        we_d, in_ready_d, busy_d;
    logic [8:0]  wa_d;
    logic [31:0] wd_d;

    logic [31:0] merged;
    logic [4:0]  next_row;
    logic [8:0]  char_addr;
    logic        accept;

    // Next-state, cursor and write-port values; every register's next value is decided here.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d      = state;
        clr_cnt_d    = clr_cnt;
        target_row_d = target_row;
        cur_word_d   = cur_word;
        row_d        = cursor_row;
        col_d        = cursor_col;
        we_d         = 1'b0;
        wa_d         = bus.write_address;
        wd_d         = bus.write_data;

        accept    = bus.in_valid && bus.in_ready;
        next_row  = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
        char_addr = 9'(cursor_row) * ROW_WORDS + 9'(cursor_col[6:2]);

        // Lane 0 starts a fresh word; later lanes build on what was just written,
        // which is valid because the row was blanked before the cursor entered it.
        merged = (cursor_col[1:0] == 2'd0) ? BLANK_WORD : cur_word;
        merged[{cursor_col[1:0], 3'b000} +: 8] = bus.in_data;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
                        cur_word_d = merged;
                        we_d       = 1'b1;
                        wa_d       = char_addr;
                        wd_d       = merged;
                        if (cursor_col == LAST_COL) begin
                            // Auto-wrap: the char write goes out first, the clear follows.
                            state_d      = CLEAR_ROW;
                            target_row_d = next_row;
                            clr_cnt_d    = 9'd0;
                        end else begin
                            col_d = cursor_col + 7'd1;
                        end
                    end else if (bus.in_data == 8'h0A) begin
                        // First clear write is issued straight from IDLE.
                        state_d      = CLEAR_ROW;
                        target_row_d = next_row;
                        we_d         = 1'b1;
                        wa_d         = 9'(next_row) * ROW_WORDS;
                        wd_d         = BLANK_WORD;
                        clr_cnt_d    = 9'd1;
                    end else if (bus.in_data == 8'h0C) begin
                        state_d   = CLEAR_SCREEN;
                        we_d      = 1'b1;
                        wa_d      = 9'd0;
                        wd_d      = BLANK_WORD;
                        clr_cnt_d = 9'd1;
                    end
                end
            end
            CLEAR_ROW: begin
                if (clr_cnt == ROW_WORDS) begin
                    state_d    = IDLE;
                    row_d      = target_row;
                    col_d      = 7'd0;
                    cur_word_d = BLANK_WORD;
                end else begin
                    we_d      = 1'b1;
                    wa_d      = 9'(target_row) * ROW_WORDS + clr_cnt;
                    wd_d      = BLANK_WORD;
                    clr_cnt_d = clr_cnt + 9'd1;
                end
            end
            CLEAR_SCREEN: begin
                if (clr_cnt == SCREEN_WORDS) begin
                    state_d    = IDLE;
                    row_d      = 5'd0;
                    col_d      = 7'd0;
                    cur_word_d = BLANK_WORD;
                end else begin
                    we_d      = 1'b1;
                    wa_d      = clr_cnt;
                    wd_d      = BLANK_WORD;
                    clr_cnt_d = clr_cnt + 9'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State register plus all registered outputs; synchronous reset aborts any clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (reset) begin
            state             <= RESET_STATE;
            clr_cnt           <= 9'd0;
            target_row        <= 5'd0;
            cur_word          <= BLANK_WORD;
            cursor_row        <= 5'd0;
            cursor_col        <= 7'd0;
            bus.write_en      <= 1'b0;
            bus.write_address <= 9'd0;
            bus.write_data    <= 32'd0;
            bus.in_ready      <= 1'b0;
            busy              <= (RESET_STATE != IDLE);
        end else begin
            state             <= state_d;
            clr_cnt           <= clr_cnt_d;
            target_row        <= target_row_d;
            cur_word          <= cur_word_d;
            cursor_row        <= row_d;
            cursor_col        <= col_d;
            bus.write_en      <= we_d;
            bus.write_address <= wa_d;
            bus.write_data    <= wd_d;
            bus.in_ready      <= in_ready_d;
            busy              <= busy_d;
        end
    end

endmodule
